// File: rtl/ex_pkg.sv
// Shared encodings for the RV32IM execute stage: M-extension ops, MD FSM states,
// forwarding selects, ALU source and ALU operation codes.
package ex_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] SRCB_RS2     = 2'b00;
  localparam logic [1:0] SRCB_IMM     = 2'b01;
  localparam logic [1:0] SRCB_FOUR    = 2'b10;
  localparam logic [1:0] SRCB_RS2_ALT = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // Divide and remainder ops all have funct3[2] set.
  function automatic logic md_is_div(input md_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu.sv
// Existing pipeline ALU selected by the 4-bit ALUCode; purely combinational.
module alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ALUCode,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] ALUResult
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = B[SHW-1:0];

  always_comb begin
    ALUResult = '0;
    case (ALUCode)
      ALU_ADD:  ALUResult = A + B;
      ALU_SUB:  ALUResult = A - B;
      ALU_SLL:  ALUResult = A << shamt;
      ALU_SLT:  ALUResult = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: ALUResult = {{(XLEN-1){1'b0}}, (A < B)};
      ALU_XOR:  ALUResult = A ^ B;
      ALU_SRL:  ALUResult = A >> shamt;
      ALU_SRA:  ALUResult = $unsigned($signed(A) >>> shamt);
      ALU_OR:   ALUResult = A | B;
      ALU_AND:  ALUResult = A & B;
      ALU_LUI:  ALUResult = B;
      default:  ALUResult = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide: shift-add MUL*, restoring DIV*/REM*,
// operating on magnitudes with a sign fix-up applied in the DONE state.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            flush,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output md_state_t       state
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_t          op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  // Request decode on the live forwarded operands.
  logic            sign_a, sign_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sign_a   = ((op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM))
               && a[XLEN-1];
    sign_b   = ((op == MD_MULH) || (op == MD_DIV) || (op == MD_REM)) && b[XLEN-1];
    mag_a    = sign_a ? (~a + 1'b1) : a;
    mag_b    = sign_b ? (~b + 1'b1) : b;
    div_zero = md_is_div(op) && (b == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (a == MIN_VAL) && (b == '1);
  end

  // One iteration step for each algorithm.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opb_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (req && !flush) begin
          op_d  = op;
          opb_d = mag_b;
          hi_d  = '0;
          lo_d  = mag_a;
          neg_d = ((op == MD_REM) || (op == MD_REMU)) ? sign_a : (sign_a ^ sign_b);
          // Special cases preload raw results so the DONE fix-up passes them through.
          if (div_zero) begin
            hi_d    = a;
            lo_d    = '1;
            neg_d   = 1'b0;
            state_d = MD_DONE;
          end else if (div_ovf) begin
            hi_d    = '0;
            lo_d    = MIN_VAL;
            neg_d   = 1'b0;
            state_d = MD_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            state_d = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        if (md_is_div(op_q)) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush) state_d = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      neg_q   <= 1'b0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Sign fix-up and half selection of the final result.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_q ? (~hi_q + 1'b1) : hi_q;
    case (op_q)
      MD_MUL:                            result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:      result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:                   result = quo_fix;
      default:                           result = rem_fix;
    endcase
  end

  assign stall = !flush && (((state_q == MD_IDLE) && req) || (state_q == MD_BUSY));
  assign state = state_q;

endmodule

// File: rtl/ex_stage_md.sv
// RV32IM execute stage: MEM-over-WB operand forwarding, ALU source selection,
// the ALU, and an iterative multiply/divide unit that stalls the front end.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ALUCode_ex,
  input  logic              ALUSrcA_ex,
  input  logic [1:0]        ALUSrcB_ex,
  input  logic [XLEN-1:0]   Imm_ex,
  input  logic [XLEN-1:0]   PC_ex,
  input  logic [REG_AW-1:0] rs1Addr_ex,
  input  logic [REG_AW-1:0] rs2Addr_ex,
  input  logic [XLEN-1:0]   rs1Data_ex,
  input  logic [XLEN-1:0]   rs2Data_ex,
  input  logic [XLEN-1:0]   ALUResult_mem,
  input  logic [REG_AW-1:0] rdAddr_mem,
  input  logic              RegWrite_mem,
  input  logic [XLEN-1:0]   RegWriteData_wb,
  input  logic [REG_AW-1:0] rdAddr_wb,
  input  logic              RegWrite_wb,
  input  logic              md_req_ex,
  input  logic [2:0]        md_op_ex,
  input  logic              flush_ex,
  output logic [XLEN-1:0]   ALUResult_ex,
  output logic [XLEN-1:0]   MemWriteData_ex,
  output logic [XLEN-1:0]   ALU_A,
  output logic [XLEN-1:0]   ALU_B,
  output logic              stall_ex
);

  fwd_sel_t        fwd_a, fwd_b;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // The MEM result is younger than WB, so it takes priority; x0 never forwards.
  always_comb begin
    fwd_a = FWD_RF;
    if (RegWrite_mem && (rdAddr_mem != '0) && (rdAddr_mem == rs1Addr_ex))
      fwd_a = FWD_MEM;
    else if (RegWrite_wb && (rdAddr_wb != '0) && (rdAddr_wb == rs1Addr_ex))
      fwd_a = FWD_WB;
    fwd_b = FWD_RF;
    if (RegWrite_mem && (rdAddr_mem != '0) && (rdAddr_mem == rs2Addr_ex))
      fwd_b = FWD_MEM;
    else if (RegWrite_wb && (rdAddr_wb != '0) && (rdAddr_wb == rs2Addr_ex))
      fwd_b = FWD_WB;
  end

  always_comb begin
    case (fwd_a)
      FWD_MEM: rs1_fwd = ALUResult_mem;
      FWD_WB:  rs1_fwd = RegWriteData_wb;
      default: rs1_fwd = rs1Data_ex;
    endcase
    case (fwd_b)
      FWD_MEM: rs2_fwd = ALUResult_mem;
      FWD_WB:  rs2_fwd = RegWriteData_wb;
      default: rs2_fwd = rs2Data_ex;
    endcase
  end

  always_comb begin
    ALU_A = ALUSrcA_ex ? PC_ex : rs1_fwd;
    case (ALUSrcB_ex)
      SRCB_IMM:  ALU_B = Imm_ex;
      SRCB_FOUR: ALU_B = XLEN'(4);
      default:   ALU_B = rs2_fwd;
    endcase
  end

  assign MemWriteData_ex = rs2_fwd;

  logic [XLEN-1:0] alu_result;

  alu #(.XLEN(XLEN)) u_alu (
    .ALUCode   (ALUCode_ex),
    .A         (ALU_A),
    .B         (ALU_B),
    .ALUResult (alu_result)
  );

  logic [XLEN-1:0] md_result;
  md_state_t       md_state;

  muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (md_req_ex),
    .flush  (flush_ex),
    .op     (md_op_t'(md_op_ex)),
    .a      (rs1_fwd),
    .b      (rs2_fwd),
    .stall  (stall_ex),
    .result (md_result),
    .state  (md_state)
  );

  assign ALUResult_ex = (md_state == MD_DONE) ? md_result : alu_result;

endmodule
